tape_pulse_player: RTL

Cassette playback source for the CPC core. It streams a pulse-length tape image from SDRAM through a 4-byte prefetch FIFO and regenerates the square-wave level that drives the motherboard `tape_in` input. Playback is gated by the motherboard's `tape_motor` output. The block sits between the SDRAM read port and the motherboard tape input, in place of the external UART_RX signal.

---
 rtl/tape_pulse_player.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tape_pulse_player.sv
// Cassette playback source: streams a pulse-length tape image from SDRAM through a
// small prefetch FIFO and regenerates the tape level. Define TAPE_TURBO_EN for double-speed playback.
module tape_pulse_player #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_4p,
  input  logic        tape_loaded,
  input  logic [24:0] tape_size,
  input  logic        rewind,
  input  logic        motor,
  input  logic        turbo,
  output logic        rd_req,
  output logic [24:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic        tape_out,
  output logic        active,
  output logic        eot,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_OP, S_LO, S_HI, S_PLAY, S_STOP
  } state_t;

  state_t      state_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [24:0] fetch_ptr_q, addr_q;
  logic        req_q, discard_q, loaded_q;
  logic [15:0] cnt_q, cnt_d, step_d;
  logic [7:0]  lo_q;
  logic        tape_q, active_q, eot_q;

  logic        fifo_empty, fifo_full, flush, push, pop, issue, fetch_done, expired;
  logic [7:0]  head;

  // SDRAM handshake: rd_req/rd_addr are held from issue until the rd_ack cycle;
  // rd_ack completes the single outstanding request and rd_req drops the next cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    head       = mem_q[rd_ptr_q];
    flush      = !tape_loaded || rewind;
    push       = req_q && rd_ack && !discard_q && !flush;
    pop        = !flush && !fifo_empty &&
                 (state_q == S_OP || state_q == S_LO || state_q == S_HI);
    fetch_done = (fetch_ptr_q >= tape_size) && !req_q;
    issue      = 1'b0;
    if (tape_loaded && !req_q) begin
      if (rewind) issue = (tape_size != '0);
      else        issue = !fifo_full && (fetch_ptr_q < tape_size);
    end
`ifdef TAPE_TURBO_EN
    step_d = turbo ? 16'd2 : 16'd1;
`else
    step_d = 16'd1;
`endif
    expired = (cnt_q <= step_d);
    cnt_d   = cnt_q - step_d;
  end

`ifndef TAPE_TURBO_EN
  logic unused_turbo;
  assign unused_turbo = turbo;
`endif

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fetch_ptr_q <= '0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      discard_q   <= 1'b0;
      loaded_q    <= 1'b0;
      cnt_q       <= '0;
      lo_q        <= '0;
      tape_q      <= 1'b0;
      active_q    <= 1'b0;
      eot_q       <= 1'b0;
    end else begin
      loaded_q <= tape_loaded;
      if (req_q && rd_ack) begin
        req_q     <= 1'b0;
        discard_q <= 1'b0;
      end
      if (issue) begin
        req_q  <= 1'b1;
        addr_q <= rewind ? 25'd0 : fetch_ptr_q;
      end
      // A request in flight during a flush still completes, but its byte is dropped.
      if (flush) begin
        fetch_ptr_q <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        if (req_q && !rd_ack) discard_q <= 1'b1;
      end else begin
        if (push) begin
          fetch_ptr_q <= fetch_ptr_q + 25'd1;
          wr_ptr_q    <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end

      if (!tape_loaded) begin
        state_q  <= S_IDLE;
        tape_q   <= 1'b0;
        eot_q    <= 1'b0;
        active_q <= 1'b0;
      end else if (rewind) begin
        state_q  <= S_OP;
        tape_q   <= 1'b0;
        eot_q    <= 1'b0;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (!loaded_q) state_q <= S_OP;
          S_OP: begin
            if (!fifo_empty) begin
              if (head != 8'd0) begin
                cnt_q    <= {5'd0, head, 3'd0};
                active_q <= 1'b1;
                state_q  <= S_PLAY;
              end else begin
                state_q <= S_LO;
              end
            end else if (fetch_done) begin
              eot_q   <= 1'b1;
              state_q <= S_STOP;
            end
          end
          S_LO: begin
            if (!fifo_empty) begin
              lo_q    <= head;
              state_q <= S_HI;
            end
          end
          S_HI: begin
            if (!fifo_empty) begin
              if ({head, lo_q} == 16'd0) begin
                eot_q   <= 1'b1;
                state_q <= S_STOP;
              end else begin
                cnt_q    <= {head, lo_q};
                active_q <= 1'b1;
                state_q  <= S_PLAY;
              end
            end
          end
          S_PLAY: begin
            if (ce_4p && motor) begin
              if (expired) begin
                tape_q   <= ~tape_q;
                active_q <= 1'b0;
                state_q  <= S_OP;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          S_STOP:  state_q <= S_STOP;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_req    = req_q;
  assign rd_addr   = addr_q;
  assign tape_out  = tape_q;
  assign active    = active_q;
  assign eot       = eot_q;
  assign dbg_state = state_q;

endmodule
